// File: rtl/round_robin_arb8.sv
// round_robin_arb8: 8-requester round-robin arbiter with done/timeout release.
// One grant at a time; the search pointer advances past each owner on release.
module round_robin_arb8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt,
    output logic       gnt_vld,
    output logic       tmo
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDXW = 3;
    localparam int unsigned CNTW = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      state_q,   state_d;
    logic [IDXW-1:0] ptr_q,     ptr_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0] gnt_q,     gnt_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            tmo_q,     tmo_d;
    logic [CNTW-1:0] hold_q,    hold_d;

    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] cand_idx;
    logic            win_found;

    // Winner search: first set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand_idx  = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = ptr_q + IDXW'(k);
            if (!win_found && req[cand_idx]) begin
                win_idx   = cand_idx;
                win_found = 1'b1;
            end
        end
    end

    // Next-state and output logic; outputs are computed here and registered below.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        tmo_d     = 1'b0;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE: begin
                gnt_vld_d = 1'b0;
                gnt_d     = '0;
                if (en && win_found) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = win_idx;
                    gnt_vld_d = 1'b1;
                    gnt_d     = NREQ'(1) << win_idx;
                    hold_d    = '0;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    // Release by owner wins over a coincident timeout.
                    state_d   = ST_IDLE;
                    gnt_vld_d = 1'b0;
                    gnt_d     = '0;
                    ptr_d     = gnt_idx_q + IDXW'(1);
                    hold_d    = '0;
                end else if (hold_q == CNTW'(TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    gnt_vld_d = 1'b0;
                    gnt_d     = '0;
                    ptr_d     = gnt_idx_q + IDXW'(1);
                    tmo_d     = 1'b1;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + CNTW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_vld_d = 1'b0;
                gnt_d     = '0;
                hold_d    = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;

endmodule
